// File: rtl/fifo_prog.sv
// Single-clock FIFO with runtime almost-full/almost-empty thresholds, a fill count,
// sticky overflow/underflow flags and an optional first-word-fall-through read port.
module fifo_prog #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FWFT       = 0,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic [AW:0]           af_thresh,
  input  logic [AW:0]           ae_thresh,
  input  logic                  clr_err,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance looks only at registered state, so a full FIFO refuses writes even during a read
  assign full         = (count == (AW+1)'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= af_thresh);
  assign almost_empty = (count <= ae_thresh);
  assign wr_acc       = wr_en & ~full;
  assign rd_acc       = rd_en & ~empty;

  // Storage is deliberately left without reset
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // A new error in the clearing cycle wins over the clear
      overflow  <= (overflow & ~clr_err) | (wr_en & full);
      underflow <= (underflow & ~clr_err) | (rd_en & empty);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dout = empty ? '0 : mem[rd_ptr];
    end else begin : g_std
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout <= '0;
        end else if (rd_acc) begin
          dout <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule
